ex_sequencer: RTL

- Execute-stage controller between decode (ID) and memory (MEM).
- Accepts one decoded op per handshake and sequences it: single-cycle ops (ADD, load address) complete in 1 cycle; R-type MUL takes MUL_CYCLES cycles on an iterative multiplier.
- Holds the result until MEM accepts it and back-pressures ID while busy.
- Replaces direct combinational use of the EX adder with a valid/ready pipeline slot.

---
 rtl/ex_pkg.sv | 12 +
 rtl/ex_if.sv | 21 ++
 rtl/ex_mul_iter.sv | 52 +++++
 rtl/ex_sequencer.sv | 67 ++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared opcodes, FSM states and op classes for the execute-stage sequencer.
package ex_pkg;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_NONE} op_t;
  function automatic op_t op_class(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_RTYPE) ? ((funct7 == F7_MULDIV) ? OP_MUL : OP_ADD) :
           (opcode == OPC_LOAD)  ? OP_ADD : OP_NONE;
  endfunction
endpackage

// File: rtl/ex_if.sv
// ex_if: ID-side op handshake and MEM-side result handshake of the execute stage.
interface ex_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;
  modport master (
    output in_valid, in_opcode, in_funct7, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_result, busy
  );
  modport slave (
    input  in_valid, in_opcode, in_funct7, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, XLEN/MUL_CYCLES multiplier bits per cycle.
module ex_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int K  = XLEN / MUL_CYCLES;
  localparam int CW = $clog2(MUL_CYCLES);
  logic [XLEN-1:0] r_a, r_b, r_acc, w_part;
  logic [CW-1:0]   r_cnt;
  logic            r_run;
  always_comb begin
    w_part = '0;
    for (int i = 0; i < K; i++) w_part = w_part + (r_b[i] ? r_a << i : '0);
  end
  // the last chunk is folded in combinationally so the product is ready on the final cycle
  assign product = r_acc + w_part;
  assign done    = r_run && r_cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (clr) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= CW'(MUL_CYCLES - 1);
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
    end else if (r_run) begin
      r_run <= r_cnt != '0;
      r_cnt <= r_cnt - 1'b1;
      r_a   <= r_a << K;
      r_b   <= r_b >> K;
      r_acc <= product;
    end
  end
endmodule

// File: rtl/ex_sequencer.sv
// ex_sequencer: execute-stage valid/ready slot; 1-cycle ADD/load, MUL_CYCLES-cycle MUL.
// Define EX_FLUSH_EN to add the flush input that abandons any held or in-flight op.
module ex_sequencer
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef EX_FLUSH_EN
  input  logic flush,
`endif
  ex_if.slave  bus
);
  state_t          r_state, w_state;
  logic [XLEN-1:0] r_result, w_result, w_product;
  logic            w_flush, w_accept, w_start, w_mul_done;
  op_t             w_op;
`ifdef EX_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif
  assign w_op           = op_class(bus.in_opcode, bus.in_funct7);
  assign bus.in_ready   = !w_flush && (r_state == IDLE || (r_state == DONE && bus.out_ready));
  assign w_accept       = bus.in_valid && bus.in_ready;
  assign w_start        = w_accept && w_op == OP_MUL;
  assign bus.out_valid  = r_state == DONE;
  assign bus.busy       = r_state == BUSY;
  assign bus.out_result = r_result;
  ex_mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_flush),
    .start   (w_start),
    .a       (bus.in_rs1),
    .b       (bus.in_rs2),
    .done    (w_mul_done),
    .product (w_product)
  );
  // an accept in DONE retires the held result and loads the new op on the same edge
  always_comb begin
    w_state  = r_state;
    w_result = r_result;
    if (w_flush) begin
      w_state = IDLE;
    end else if (w_accept) begin
      w_state  = (w_op == OP_MUL) ? BUSY : DONE;
      w_result = (w_op == OP_ADD) ? bus.in_rs1 + bus.in_rs2 : (w_op == OP_NONE) ? '0 : r_result;
    end else if (r_state == BUSY && w_mul_done) begin
      w_state  = DONE;
      w_result = w_product;
    end else if (r_state == DONE && bus.out_ready) begin
      w_state = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
    end else begin
      r_state  <= w_state;
      r_result <= w_result;
    end
  end
endmodule
